// File: rtl/necpu_pkg.sv
// Shared NECPU definitions for the fetch front end.
//   fetch_state_e  : fetch controller FSM encoding (IDLE / FETCH / HALT)
//   NECPU_ADDR_W   : default word-address width
//   NECPU_INST_W   : instruction width
package necpu_pkg;

  localparam int NECPU_ADDR_W = 32;
  localparam int NECPU_INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_dbg_arb.sv
// Debug/fetch arbiter for the shared instruction memory port.
// The debug requester gets the memory whenever fetch does not want it. If fetch
// keeps it busy, the request is force-granted once it has waited DBG_MAX_WAIT cycles.
// A granted read is returned one cycle later with a single-cycle ack.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   fetch_want   fetch would like the memory this cycle
//   dbg_req      debug read request (held until dbg_ack)
//   imem_inst    memory read data for the address driven this cycle
//   dbg_grant    memory address is the debug address this cycle
//   fetch_go     fetch owns the memory and proceeds this cycle
//   dbg_ack      one-cycle pulse, dbg_inst valid
//   dbg_inst     captured debug read data
module fetch_dbg_arb
  import necpu_pkg::*;
#(
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_want,
  input  logic                    dbg_req,
  input  logic [NECPU_INST_W-1:0] imem_inst,
  output logic                    dbg_grant,
  output logic                    fetch_go,
  output logic                    dbg_ack,
  output logic [NECPU_INST_W-1:0] dbg_inst
);

  localparam int SW = $clog2(DBG_MAX_WAIT + 1);

  logic [SW-1:0] starve;
  logic          forced;

  // No grant during the ack cycle: the requester is dropping its request there.
  always_comb begin
    forced    = (starve == SW'(DBG_MAX_WAIT));
    dbg_grant = dbg_req && !dbg_ack && (!fetch_want || forced);
    fetch_go  = fetch_want && !dbg_grant;
  end

  // Starve counter saturates so a forced grant stays pending until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve   <= '0;
      dbg_ack  <= 1'b0;
      dbg_inst <= '0;
    end else begin
      dbg_ack <= dbg_grant;
      if (dbg_grant) begin
        dbg_inst <= imem_inst;
        starve   <= '0;
      end else if (dbg_req && !dbg_ack && !forced) begin
        starve <= starve + SW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// NECPU instruction-fetch controller.
// Owns the PC, drives the external combinational instruction memory and presents
// fetched instructions as a registered valid/ready stream toward decode. Supports
// branch redirect, halt/start and a debug read port sharing the memory.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, halt_req            resume fetching / stop issuing fetches
//   redirect_valid, redirect_pc flush and reload PC
//   imem_addr, imem_inst       instruction memory address / same-cycle data
//   out_valid, out_ready, out_inst, out_pc   stream toward decode
//   dbg_req, dbg_addr, dbg_ack, dbg_inst     debug read port
//   running                    1 while in FETCH
module fetch_ctrl
  import necpu_pkg::*;
#(
  parameter int               ADDR_W       = NECPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int               DBG_MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    halt_req,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [NECPU_INST_W-1:0] imem_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NECPU_INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0]       out_pc,
  input  logic                    dbg_req,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic                    dbg_ack,
  output logic [NECPU_INST_W-1:0] dbg_inst,
  output logic                    running
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              fetch_want;
  logic              fetch_go;
  logic              dbg_grant;

  // Fetch only when the output slot is free or being drained this cycle.
  assign fetch_want = (state == ST_FETCH) && !redirect_valid && (!out_valid || out_ready);
  assign imem_addr  = dbg_grant ? dbg_addr : pc;
  assign running    = (state == ST_FETCH);

  fetch_dbg_arb #(
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .fetch_want(fetch_want),
    .dbg_req   (dbg_req),
    .imem_inst (imem_inst),
    .dbg_grant (dbg_grant),
    .fetch_go  (fetch_go),
    .dbg_ack   (dbg_ack),
    .dbg_inst  (dbg_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // halt_req always beats start.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start && !halt_req) state_next = ST_FETCH;
      ST_FETCH: if (halt_req)           state_next = ST_HALT;
      ST_HALT:  if (start && !halt_req) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Redirect flushes any held instruction; otherwise fetch refills or accept drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      out_valid <= 1'b0;
    end else if (fetch_go) begin
      out_inst  <= imem_inst;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc + ADDR_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// The instruction memory is modelled as mem[k] = k + 100.
module tb_fetch_ctrl;

  localparam int ADDR_W       = 32;
  localparam int DBG_MAX_WAIT = 8;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              halt_req = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_inst;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic              dbg_ack;
  logic [31:0]       dbg_inst;
  logic              running;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  always #5 clk = ~clk;

  assign imem_inst = imem_addr + 32'd100;

  fetch_ctrl #(
    .ADDR_W(ADDR_W),
    .RESET_PC('0),
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_inst(dbg_inst),
    .running(running)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are stable there too.
  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    start          = s;
    halt_req       = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  // Behavioural model: expected outputs after each rising edge.
  int          m_state;
  logic [31:0] m_pc, m_out_pc, m_out_inst, m_dbg_inst;
  logic        m_valid, m_ack;
  int          m_waited;

  always @(posedge clk) begin : model
    bit want, grant, go;
    if (rst) begin
      m_state <= M_IDLE; m_pc <= '0; m_valid <= 0; m_out_pc <= '0; m_out_inst <= '0;
      m_ack <= 0; m_dbg_inst <= '0; m_waited <= 0;
    end else begin
      want  = (m_state == M_FETCH) && !redirect_valid && (!m_valid || out_ready);
      grant = dbg_req && !m_ack && (!want || m_waited >= DBG_MAX_WAIT);
      go    = want && !grant;
      m_ack <= grant;
      if (grant) m_dbg_inst <= dbg_addr + 32'd100;
      if (grant) m_waited <= 0;
      else if (dbg_req && !m_ack && m_waited < DBG_MAX_WAIT) m_waited <= m_waited + 1;
      if (redirect_valid) begin
        m_pc <= redirect_pc; m_valid <= 0;
      end else if (go) begin
        m_out_pc <= m_pc; m_out_inst <= m_pc + 32'd100; m_valid <= 1; m_pc <= m_pc + 32'd1;
      end else if (m_valid && out_ready) begin
        m_valid <= 0;
      end
      if (m_state == M_IDLE && start && !halt_req) m_state <= M_FETCH;
      else if (m_state == M_FETCH && halt_req)    m_state <= M_HALT;
      else if (m_state == M_HALT && start && !halt_req) m_state <= M_FETCH;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      checkOutput("model out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      checkOutput("model out_pc", out_pc, m_out_pc);
      checkOutput("model out_inst", out_inst, m_out_inst);
      checkOutput("model dbg_ack", {31'd0, dbg_ack}, {31'd0, m_ack});
      checkOutput("model running", {31'd0, running}, {31'd0, m_state == M_FETCH});
      if (m_ack) checkOutput("model dbg_inst", dbg_inst, m_dbg_inst);
    end
  end

  initial begin : main
    int n;
    logic [31:0] saved_pc;
    int pend;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset state, then start streaming.
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_pc", out_pc, 32'd0);
    checkOutput("reset running", {31'd0, running}, 32'd0);
    checkOutput("reset dbg_ack", {31'd0, dbg_ack}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("start running", {31'd0, running}, 32'd1);
    checkOutput("start no valid yet", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, (k == 2) ? 1'b0 : 1'b1);
      checkOutput("stream valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream out_pc", out_pc, k);
      checkOutput("stream out_inst", out_inst, k + 100);
    end

    // Stall for three cycles at out_pc 2.
    for (int j = 0; j < 3; j++) begin
      applyStimulus(0, 0, 0, 0, 0, (j == 2) ? 1'b1 : 1'b0);
      checkOutput("stall out_pc", out_pc, 32'd2);
      checkOutput("stall out_inst", out_inst, 32'd102);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("resume out_pc", out_pc, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("resume out_pc", out_pc, 32'd4);

    // Redirect to 12 while out_pc 5 is held.
    applyStimulus(0, 0, 0, 1, 32'd12, 1);
    checkOutput("pre-redirect out_pc", out_pc, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("redirect flush", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("redirect out_pc", out_pc, 32'd12);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("redirect out_pc", out_pc, 32'd13);

    // Debug read while streaming: forced grant after the starve limit.
    dbg_req = 1'b1; dbg_addr = 32'd7;
    n = 0;
    while (n < 20 && !dbg_ack) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      n++;
    end
    dbg_req = 1'b0;
    checkOutput("dbg latency", n, 32'd9);
    checkOutput("dbg_inst", dbg_inst, 32'd107);
    checkOutput("dbg bubble", {31'd0, out_valid}, 32'd0);

    // Halt, debug read in HALT, resume.
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("halt running", {31'd0, running}, 32'd0);
    checkOutput("halt last fetch", {31'd0, out_valid}, 32'd1);
    saved_pc = out_pc;
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("halt no fetch", {31'd0, out_valid}, 32'd0);
    dbg_req = 1'b1; dbg_addr = 32'd3;
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("halt dbg_ack", {31'd0, dbg_ack}, 32'd1);
    checkOutput("halt dbg_inst", dbg_inst, 32'd103);
    dbg_req = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("halt still stopped", {31'd0, running}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("resume running", {31'd0, running}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("resume saved pc", out_pc, saved_pc + 32'd1);

    // PC wrap from all-ones to zero.
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("wrap flush", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("wrap out_pc max", out_pc, 32'hFFFF_FFFF);
    checkOutput("wrap out_inst", out_inst, 32'd99);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("wrap out_pc zero", out_pc, 32'd0);

    // Reset mid-stream.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst out_pc", out_pc, 32'd0);
    checkOutput("rst out_inst", out_inst, 32'd0);
    checkOutput("rst running", {31'd0, running}, 32'd0);
    checkOutput("rst dbg_inst", dbg_inst, 32'd0);

    // Randomized traffic.
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, s, h, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 399) == 0);
      s   = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 19) == 0) ? !halt_req : halt_req;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 63);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, s, h, rv, rpc, rdy);
      if (dbg_req && dbg_ack) begin
        checkOutput("dbg wait bound", {31'd0, pend <= DBG_MAX_WAIT}, 32'd1);
        dbg_req = 1'b0;
        pend = 0;
      end else if (!dbg_req && $urandom_range(0, 9) == 0) begin
        dbg_req  = 1'b1;
        dbg_addr = $urandom;
        pend = 0;
      end else if (dbg_req) begin
        pend++;
      end
      if (r) pend = 0;
    end

    applyStimulus(0, 0, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
